antisat_key_loader: RTL and testbench
=====================================

ANTISAT_KEY_LOADER -- requirements
Module: antisat_key_loader

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 34, key bits delivered to the Anti-SAT block (2 x 17 inputs).
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles allowed between serial beats before abort.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a key load.
REQ-007 SHALL have port clear  input  1  zeroize key and return to idle.
REQ-008 SHALL have port ser_valid  input  1  serial bit present on ser_data.
REQ-009 SHALL have port ser_data  input  1  serial key bit, LSB first.
REQ-010 SHALL have port ser_ready  output  1  loader accepts a bit this cycle.
REQ-011 SHALL have port key_out  output  KEY_WIDTH  key to keyIn_0_0..keyIn_0_(KEY_WIDTH-1), bit i to keyIn_0_i.
REQ-012 SHALL have port key_valid  output  1  key_out holds a verified key.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port load_err  output  1  last load aborted.

Function
REQ-015 SHALL implement states IDLE, SHIFT, CHECK, LOADED, ERROR.
REQ-016 SHALL go IDLE->SHIFT on start=1; bit counter and timeout counter cleared.
REQ-017 SHALL assert ser_ready only in SHIFT; a beat transfers when ser_valid&&ser_ready.
REQ-018 SHALL store the n-th transferred key bit (n from 0) into shadow bit n; key_out is not updated during SHIFT.
REQ-019 SHALL move SHIFT->CHECK on the clock edge of the final frame beat; CHECK lasts exactly one cycle.
REQ-020 SHALL on check pass copy shadow to key_out and enter LOADED; key_valid=1 from the cycle after CHECK (2 cycles after final beat).
REQ-021 SHALL on check fail enter ERROR with key_out=0, key_valid=0, load_err=1.
REQ-022 SHALL reset the timeout counter on every transfer and move SHIFT->ERROR when it reaches TIMEOUT consecutive non-transfer cycles.
REQ-023 SHALL ignore start in SHIFT, CHECK and LOADED; start in ERROR begins a new load (SHIFT) and clears load_err.
REQ-024 SHALL on clear=1 in any state go to IDLE next cycle with key_out=0, key_valid=0, load_err=0, shadow=0; clear beats start and any simultaneous transfer.
REQ-025 SHALL drive busy=1 in SHIFT and CHECK, 0 otherwise.
REQ-026 SHALL hold key_out stable in LOADED until clear or rst; ser_valid beats in non-SHIFT states are dropped.

Reset
REQ-027 SHALL on rst=1 enter IDLE with key_out=0, key_valid=0, busy=0, load_err=0, ser_ready=0, counters and shadow zero.
REQ-028 SHALL give rst priority over clear, start and transfers, including mid-SHIFT; a partial key is never presented.

Configuration
REQ-029 SHALL with KEY_PARITY_CHECK_EN defined use a KEY_WIDTH+1 bit frame, last bit even parity over the key; CHECK fails on mismatch.
REQ-030 SHALL with KEY_PARITY_CHECK_EN undefined use a KEY_WIDTH bit frame; CHECK always passes; ERROR reachable only by timeout.

Verification
REQ-031 SHALL cover: start, 34 back-to-back beats of 34'h2_AAAA_5555 (parity macro off) -> key_valid=1 two cycles after last beat, key_out=34'h2_AAAA_5555.
REQ-032 SHALL cover: macro on, key 34'h0_0000_0001 with parity bit 0 -> load_err=1, key_out=0; retry with parity 1 -> key_valid=1, key_out=34'h1.
REQ-033 SHALL cover: start, 10 beats then ser_valid=0 for 255 cycles -> ERROR, load_err=1, ser_ready=0.
REQ-034 SHALL cover: clear asserted same cycle as final beat -> next cycle IDLE, key_valid=0, key_out=0.
REQ-035 SHALL cover: rst pulsed mid-SHIFT after 20 beats, then full load of 34'h3_FFFF_FFFF -> key_out=34'h3_FFFF_FFFF, no residue.
REQ-036 SHALL cover: start asserted while LOADED with ser_valid toggling -> key_out and key_valid unchanged.

Source files
------------

// File: rtl/antisat_key_loader.sv
// antisat_key_loader: serial key loader that shifts an LSB-first key frame
// into a shadow register, checks it, and presents it to the Anti-SAT block.
// Ports: clk, rst (sync, active-high), start, clear, ser_valid, ser_data,
//        ser_ready, key_out[KEY_WIDTH-1:0], key_valid, busy, load_err.
// Macro KEY_PARITY_CHECK_EN: frame gains a trailing even-parity bit that
// CHECK verifies; undefined, the frame is the bare key and CHECK passes.
module antisat_key_loader #(
  parameter int KEY_WIDTH = 34,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  output logic                 ser_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_err
);

`ifdef KEY_PARITY_CHECK_EN
  localparam int FRAME = KEY_WIDTH + 1;
`else
  localparam int FRAME = KEY_WIDTH;
`endif

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST    = CW'(FRAME - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, CHECK, LOADED, ERROR
  } state_t;

  state_t            state, nxt;
  logic [FRAME-1:0]  shadow;
  logic [CW-1:0]     bit_cnt;
  logic [TW-1:0]     to_cnt;
  logic              xfer;
  logic              chk_ok;
  logic              begin_load;

  assign xfer       = ser_valid && (state == SHIFT);
  assign begin_load = start && (state == IDLE || state == ERROR);

`ifdef KEY_PARITY_CHECK_EN
  // Parity bit equals XOR of key bits, so the whole frame XORs to zero.
  assign chk_ok = ~^shadow;
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (start) nxt = SHIFT;
      SHIFT: begin
        if (xfer && bit_cnt == LAST)       nxt = CHECK;
        else if (!xfer && to_cnt == TO_LAST) nxt = ERROR;
      end
      CHECK:  nxt = chk_ok ? LOADED : ERROR;
      LOADED: nxt = LOADED;
      ERROR:  if (start) nxt = SHIFT;
      default: nxt = IDLE;
    endcase
    if (clear) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      key_out <= '0;
    end else begin
      state <= nxt;
      if (clear) begin
        shadow  <= '0;
        bit_cnt <= '0;
        to_cnt  <= '0;
        key_out <= '0;
      end else begin
        if (begin_load) begin
          shadow  <= '0;
          bit_cnt <= '0;
          to_cnt  <= '0;
        end
        if (xfer) begin
          shadow[bit_cnt] <= ser_data;
          bit_cnt         <= bit_cnt + 1'b1;
          to_cnt          <= '0;
        end else if (state == SHIFT) begin
          to_cnt <= to_cnt + 1'b1;
        end
        if (state == CHECK)
          key_out <= chk_ok ? shadow[KEY_WIDTH-1:0] : '0;
      end
    end
  end

  assign ser_ready = (state == SHIFT);
  assign busy      = (state == SHIFT) || (state == CHECK);
  assign key_valid = (state == LOADED);
  assign load_err  = (state == ERROR);

endmodule

// File: tb/tb_antisat_key_loader.sv
// tb_antisat_key_loader: directed, table-driven self-checking bench
// for antisat_key_loader with default parameters.
module tb_antisat_key_loader;

  localparam int KW = 34;
`ifdef KEY_PARITY_CHECK_EN
  localparam int FR = KW + 1;
`else
  localparam int FR = KW;
`endif

  logic          clk = 1'b0;
  logic          rst, start, clear, ser_valid, ser_data;
  logic          ser_ready, key_valid, busy, load_err;
  logic [KW-1:0] key_out;

  int n_chk = 0;
  int n_err = 0;

  antisat_key_loader #(.KEY_WIDTH(KW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
    .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic [KW-1:0] exp_key;
    logic          exp_valid;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Send beats [0, n) of frame f back to back.
  task automatic send(input logic [KW:0] f, input int n);
    ser_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      ser_data = f[i];
      step();
    end
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  function automatic logic [KW:0] frm(input logic [KW-1:0] k);
    return {^k, k};
  endfunction

  initial begin
    logic [KW:0] f;
    tbl[0] = '{34'h2_AAAA_5555, 34'h2_AAAA_5555, 1'b1, 1'b0};
    tbl[1] = '{34'h0_0000_0000, 34'h0_0000_0000, 1'b1, 1'b0};
    tbl[2] = '{34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b1, 1'b0};
    tbl[3] = '{34'h0_0000_0001, 34'h0_0000_0001, 1'b1, 1'b0};
    tbl[4] = '{34'h2_0000_0000, 34'h2_0000_0000, 1'b1, 1'b0};
    tbl[5] = '{34'h1_2345_6789, 34'h1_2345_6789, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; clear = 1'b0;
    ser_valid = 1'b0; ser_data = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_key", 64'(key_out), 64'h0);
    chk("rst_valid", 64'(key_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(load_err), 64'h0);
    chk("rst_ready", 64'(ser_ready), 64'h0);

    // Table: full loads with correct framing.
    for (int v = 0; v < 6; v++) begin
      do_clear();
      chk("tbl_clr_valid", 64'(key_valid), 64'h0);
      do_start();
      chk("tbl_ready", 64'(ser_ready), 64'h1);
      send(frm(tbl[v].key), FR);
      chk("tbl_chk_busy", 64'(busy), 64'h1);
      chk("tbl_chk_valid", 64'(key_valid), 64'h0);
      step();
      chk("tbl_key", 64'(key_out), 64'(tbl[v].exp_key));
      chk("tbl_valid", 64'(key_valid), 64'(tbl[v].exp_valid));
      chk("tbl_err", 64'(load_err), 64'(tbl[v].exp_err));
      chk("tbl_busy", 64'(busy), 64'h0);
    end

    // Start and serial traffic while LOADED are ignored.
    start = 1'b1;
    ser_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ser_data = i[0];
      ser_valid = ~i[0];
      step();
      chk("ldd_key", 64'(key_out), 64'h1_2345_6789);
      chk("ldd_valid", 64'(key_valid), 64'h1);
      chk("ldd_ready", 64'(ser_ready), 64'h0);
    end
    start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;

    // Timeout: 10 beats, then 255 idle cycles.
    do_clear();
    do_start();
    send(frm(34'h3_FFFF_FFFF), 10);
    for (int i = 0; i < 254; i++) step();
    chk("to_pre_busy", 64'(busy), 64'h1);
    chk("to_pre_err", 64'(load_err), 64'h0);
    step();
    chk("to_err", 64'(load_err), 64'h1);
    chk("to_ready", 64'(ser_ready), 64'h0);
    chk("to_busy", 64'(busy), 64'h0);
    chk("to_key", 64'(key_out), 64'h0);
    // Start from ERROR begins a fresh load.
    do_start();
    chk("re_err", 64'(load_err), 64'h0);
    chk("re_busy", 64'(busy), 64'h1);
    send(frm(34'h0_F0F0_1234), FR);
    step();
    chk("re_key", 64'(key_out), 64'h0_F0F0_1234);
    chk("re_valid", 64'(key_valid), 64'h1);

    // Clear coincident with the final beat.
    do_clear();
    do_start();
    f = frm(34'h2_AAAA_5555);
    send(f, FR - 1);
    ser_valid = 1'b1;
    ser_data = f[FR-1];
    clear = 1'b1;
    step();
    clear = 1'b0; ser_valid = 1'b0;
    chk("clr_valid", 64'(key_valid), 64'h0);
    chk("clr_key", 64'(key_out), 64'h0);
    chk("clr_busy", 64'(busy), 64'h0);
    step(); step();
    chk("clr_valid2", 64'(key_valid), 64'h0);
    chk("clr_key2", 64'(key_out), 64'h0);

    // Reset mid-SHIFT, then a clean full load.
    do_start();
    send(frm(34'h1_5555_AAAA), 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_key", 64'(key_out), 64'h0);
    do_start();
    send(frm(34'h3_FFFF_FFFF), FR);
    step();
    chk("mrst_key2", 64'(key_out), 64'h3_FFFF_FFFF);
    chk("mrst_valid", 64'(key_valid), 64'h1);

`ifdef KEY_PARITY_CHECK_EN
    // Bad parity aborts, good parity loads.
    do_clear();
    do_start();
    send({1'b0, 34'h0_0000_0001}, FR);
    step();
    chk("par_bad_err", 64'(load_err), 64'h1);
    chk("par_bad_key", 64'(key_out), 64'h0);
    chk("par_bad_valid", 64'(key_valid), 64'h0);
    do_start();
    send({1'b1, 34'h0_0000_0001}, FR);
    step();
    chk("par_ok_valid", 64'(key_valid), 64'h1);
    chk("par_ok_key", 64'(key_out), 64'h1);
    chk("par_ok_err", 64'(load_err), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
